// File: rtl/sample_gen_pkg.sv
// Shared types and helpers for the multi-channel sample strobe generator.
package sample_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Divisor loaded at reset: 50 MHz / (2499 + 1) = 20 kHz.
  localparam int unsigned SG_DEF_DIV = 2499;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/sample_gen_ch.sv
// One sample-enable channel: run/idle FSM, period counter, burst counter and
// shadowed runtime config. Start-phase storage exists only with SAMPLE_GEN_PHASE_EN.
module sample_gen_ch
  import sample_gen_pkg::*;
#(
  parameter int          DIV_W   = 16,
  parameter int          BURST_W = 16,
  parameter int unsigned DEF_DIV = SG_DEF_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [DIV_W-1:0]   wr_div,
  input  logic [DIV_W-1:0]   wr_phase,
  input  logic [BURST_W-1:0] wr_burst,
  input  logic               start,
  input  logic               stop,
  output logic               sample_en,
  output logic               busy,
  output logic               done
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);

  typedef struct packed {
    logic [DIV_W-1:0]   div;
`ifdef SAMPLE_GEN_PHASE_EN
    logic [DIV_W-1:0]   phase;
`endif
    logic [BURST_W-1:0] burst;
  } ch_cfg_t;

  ch_state_e          state_q, state_d;
  ch_cfg_t            cfg_q, cfg_d;
  ch_cfg_t            sh_q, sh_d;
  ch_cfg_t            wr_cfg;
  logic               pend_q, pend_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] strb_q, strb_d;
  logic [BURST_W-1:0] strb_inc;
  logic               sample_en_q, sample_en_d;
  logic               done_q, done_d;
  logic [DIV_W-1:0]   eff_phase;
  logic               wrap;
  logic               wr_direct;
  logic               wr_shadow;

`ifdef SAMPLE_GEN_PHASE_EN
  assign wr_cfg    = '{div: wr_div, phase: wr_phase, burst: wr_burst};
  // An out-of-range phase would never meet div, so it falls back to 0.
  assign eff_phase = (cfg_q.phase <= cfg_q.div) ? cfg_q.phase : '0;
`else
  logic unused_phase;
  assign unused_phase = ^wr_phase;
  assign wr_cfg       = '{div: wr_div, burst: wr_burst};
  assign eff_phase    = '0;
`endif

  assign wrap      = (cnt_q == cfg_q.div);
  assign strb_inc  = strb_q + BURST_W'(1);
  assign wr_direct = wr_en && (state_q == ST_IDLE);
  assign wr_shadow = wr_en && (state_q == ST_RUN);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d     = state_q;
    cfg_d       = cfg_q;
    sh_d        = sh_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    strb_d      = strb_q;
    sample_en_d = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          cnt_d   = eff_phase;
          strb_d  = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          cnt_d  = eff_phase;
          strb_d = '0;
        end else if (done_q) begin
          // Last burst strobe was shown last cycle; leave one cycle later.
          state_d = ST_IDLE;
        end else if (wrap) begin
          sample_en_d = 1'b1;
          cnt_d       = '0;
          strb_d      = strb_inc;
          done_d      = (cfg_q.burst != '0) && (strb_inc >= cfg_q.burst);
          if (pend_q) begin
            cfg_d  = sh_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write on a wrap cycle lands after the old shadow was consumed above.
    if (wr_direct) begin
      cfg_d  = wr_cfg;
      pend_d = 1'b0;
    end else if (wr_shadow) begin
      sh_d   = wr_cfg;
      pend_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      // NOTE: config and shadow registers are reset too, so a start before
      // any write runs from a known divisor.
      cfg_q       <= '0;
      cfg_q.div   <= RST_DIV;
      sh_q        <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      strb_q      <= '0;
      sample_en_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      sh_q        <= sh_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      strb_q      <= strb_d;
      sample_en_q <= sample_en_d;
      done_q      <= done_d;
    end
  end

  assign sample_en = sample_en_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: rtl/sample_strobe_gen.sv
// Multi-channel runtime-programmable sample-enable generator: config decode,
// cfg_ready and N_CH channel instances. Optional start phase: SAMPLE_GEN_PHASE_EN.
module sample_strobe_gen
  import sample_gen_pkg::*;
#(
  parameter int          N_CH    = 4,
  parameter int          DIV_W   = 16,
  parameter int          BURST_W = 16,
  parameter int unsigned DEF_DIV = SG_DEF_DIV,
  localparam int         CH_W    = ch_idx_w(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DIV_W-1:0]   cfg_phase,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [N_CH-1:0]    start,
  input  logic [N_CH-1:0]    stop,
  output logic [N_CH-1:0]    sample_en,
  output logic [N_CH-1:0]    busy,
  output logic [N_CH-1:0]    done
);

  logic            cfg_ready_q, cfg_ready_d;
  logic            cfg_fire;
  logic [N_CH-1:0] wr_en;

  assign cfg_ready_d = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_fire  = cfg_valid && cfg_ready_q;

  // Indices at or above N_CH match no channel, so such writes are dropped.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_en[i] = cfg_fire && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sample_gen_ch #(
      .DIV_W   (DIV_W),
      .BURST_W (BURST_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en[g]),
      .wr_div    (cfg_div),
      .wr_phase  (cfg_phase),
      .wr_burst  (cfg_burst),
      .start     (start[g]),
      .stop      (stop[g]),
      .sample_en (sample_en[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

endmodule
